mvm_out_serializer: RTL and testbench
=====================================

Name: mvm_out_serializer

Overview:
- Downstream of the MVM engine; consumes one NUM_OLANES-wide set of accumulator results per result-valid pulse.
- Buffers result sets in a small FIFO, since the engine cannot be stalled.
- Requantizes each lane (round, arithmetic shift, saturate) and streams the lanes out one per cycle over a valid/ready interface.
- Flags overflow when a set arrives with no room to store it.

Parameters:
- NUM_OLANES, 8, lanes per result set.
- DATAW, 32, signed input lane width (matches engine OWIDTH).
- OWIDTH, 8, signed output element width.
- SET_DEPTH, 4, FIFO depth in whole result sets (power of 2).
- SHIFTW, $clog2(DATAW), width of shift amount.
- LANEW, $clog2(NUM_OLANES), lane index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_result  in  [DATAW-1:0] x NUM_OLANES  signed lane results.
- i_valid  in  1  one-cycle pulse: i_result holds a complete set.
- i_shift  in  SHIFTW  right-shift amount; static while o_busy=1.
- i_clr_ovf  in  1  clears o_overflow.
- i_ready  in  1  downstream ready.
- o_data  out  OWIDTH  requantized lane value.
- o_lane  out  LANEW  lane index of o_data.
- o_last  out  1  high with lane NUM_OLANES-1.
- o_valid  out  1  o_data/o_lane/o_last valid.
- o_count  out  $clog2(SET_DEPTH)+1  sets held in the FIFO.
- o_overflow  out  1  sticky: a set was dropped.
- o_busy  out  1  FIFO non-empty or o_valid.

Behaviour:
- Reset (rst=0, async):
  - o_data=0, o_lane=0, o_last=0, o_valid=0, o_count=0, o_overflow=0, o_busy=0.
  - FIFO pointers and lane counter are 0.
  - Reset mid-stream discards all buffered sets.
- Write:
  - On i_valid, the set is written at the write pointer if count<SET_DEPTH.
  - A write is also accepted if count==SET_DEPTH and the head set is popped in the same cycle.
  - Otherwise the set is dropped, o_overflow is set and count is unchanged.
- Pointers wrap modulo SET_DEPTH.
- Output register load:
  - Load condition: (o_valid==0 or i_ready==1) and count>0.
  - On load: o_data=requant(head[lane_cnt]), o_lane=lane_cnt, o_last=(lane_cnt==NUM_OLANES-1), o_valid=1.
  - After loading the last lane, lane_cnt returns to 0 and the head set is popped.
  - If the load condition is false and i_ready=1, o_valid drops to 0.
  - Outputs hold stable while o_valid=1 and i_ready=0.
- Latency: i_valid at edge N into an empty block gives o_valid=1 after edge N+1 with lane 0.
- Throughput: one lane per cycle while i_ready=1, continuous across back-to-back sets with no bubble.
- o_count: simultaneous write and pop leaves it unchanged; otherwise +1 on write, -1 on pop.
- Requant, computed at DATAW+1 bits to avoid overflow:
  - If i_shift>0, add 1<<(i_shift-1) (round half up).
  - Arithmetic right shift by i_shift.
  - Saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
  - i_shift=0 is saturation only.
- Overflow flag:
  - Cleared by i_clr_ovf.
  - If a drop and i_clr_ovf occur in the same cycle, the flag stays set.
- States:
  - IDLE: count=0, o_valid=0.
  - STREAM: emitting lanes.
  - IDLE→STREAM on first load; STREAM→IDLE when the last lane is accepted and count==0.

Decomposition:
- Shared package mvm_pkg:
  - Constants NUM_OLANES, DATAW, OWIDTH.
  - Lane index typedef.
  - Function sat_round_shift(value, shift) returning OWIDTH-bit signed.
- One sub-module, mvm_set_fifo: SET_DEPTH x (NUM_OLANES*DATAW) register FIFO with push/pop/count/full/empty and the pop-while-full write rule.

Test Plan:
- Single set, shift=4, lanes {24,-24,5000,-5000,0,8,-8,127}, i_ready=1 -> o_data {2,-1,127,-128,0,1,0,8}.
  - Lanes 0..7 appear on consecutive cycles starting 2 cycles after i_valid.
  - o_last only on lane 7; o_busy falls one cycle after lane 7 is accepted.
- i_ready=0 for 5 cycles mid-set -> o_data/o_lane frozen; on release, streaming resumes at the same lane with no loss or duplicate.
- i_ready=0, 5 i_valid pulses (SET_DEPTH=4) -> o_count=4, o_overflow=1, the 5th set is absent from output.
  - Then i_clr_ovf -> o_overflow=0.
- Full FIFO: i_valid in the same cycle the last lane of the head set is accepted -> set accepted, o_count stays 4, o_overflow stays 0.
- Back-to-back sets with i_ready=1 -> 16 consecutive valid cycles, lanes 0..7 twice, o_last at cycles 8 and 16.
- Assert rst=0 asynchronously mid-stream -> all outputs 0 immediately, FIFO empty.
  - After release, a new set streams correctly from lane 0.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared constants, types and the lane requantizer for the MVM output path.
package mvm_pkg;

    localparam int NUM_OLANES = 8;
    localparam int DATAW      = 32;
    localparam int OWIDTH     = 8;
    localparam int SHIFTW     = $clog2(DATAW);
    localparam int LANEW      = $clog2(NUM_OLANES);

    typedef logic [LANEW-1:0]  lane_t;
    typedef logic [SHIFTW-1:0] shift_t;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

    localparam logic signed [DATAW:0] EXT_MAX = (DATAW+1)'(2**(OWIDTH-1) - 1);
    localparam logic signed [DATAW:0] EXT_MIN = (DATAW+1)'(-(2**(OWIDTH-1)));

    // One extra bit keeps the rounding add from wrapping at the top of the range.
    function automatic logic signed [OWIDTH-1:0] sat_round_shift(
        input logic signed [DATAW-1:0] value,
        input shift_t                  shift
    );
        logic signed [DATAW:0] ext;
        logic signed [DATAW:0] one;
        ext = {value[DATAW-1], value};
        one = {{DATAW{1'b0}}, 1'b1};
        if (shift != '0)
            ext = ext + (one << (shift - 1'b1));
        ext = ext >>> shift;
        if (ext > EXT_MAX)
            return OWIDTH'(EXT_MAX);
        else if (ext < EXT_MIN)
            return OWIDTH'(EXT_MIN);
        else
            return OWIDTH'(ext);
    endfunction

endpackage

// File: rtl/mvm_set_fifo.sv
// Register FIFO holding whole result sets; a push into a full FIFO succeeds
// only when the head is popped in the same cycle.
module mvm_set_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wptr;
    logic [PTRW-1:0]  rptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rptr];

    // NOTE: storage is deliberately not reset; count/empty gate every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= wdata;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_en)
                rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_out_serializer.sv
// Buffers accumulator result sets and streams requantized lanes one per cycle
// over valid/ready; flags sets dropped for lack of room.
module mvm_out_serializer
    import mvm_pkg::*;
#(
    parameter int SET_DEPTH = 4,
    localparam int CNTW = $clog2(SET_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_OLANES*DATAW-1:0] i_result,
    input  logic                        i_valid,
    input  logic [SHIFTW-1:0]           i_shift,
    input  logic                        i_clr_ovf,
    input  logic                        i_ready,
    output logic [OWIDTH-1:0]           o_data,
    output logic [LANEW-1:0]            o_lane,
    output logic                        o_last,
    output logic                        o_valid,
    output logic [CNTW-1:0]             o_count,
    output logic                        o_overflow,
    output logic                        o_busy
);

    ser_state_t                  state;
    ser_state_t                  state_nxt;
    logic [NUM_OLANES*DATAW-1:0] head;
    logic signed [DATAW-1:0]     lane_value;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        load;
    logic                        pop;
    logic                        drop;
    logic                        last_lane;
    lane_t                       lane_cnt;

    mvm_set_fifo #(
        .DEPTH (SET_DEPTH),
        .WIDTH (NUM_OLANES*DATAW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_valid),
        .pop   (pop),
        .wdata (i_result),
        .rdata (head),
        .count (o_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_lane  = (lane_cnt == lane_t'(NUM_OLANES - 1));
    assign lane_value = head[DATAW*int'(lane_cnt) +: DATAW];
    assign drop       = i_valid && fifo_full && !pop;
    assign o_busy     = (state == STREAM) || !fifo_empty;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        load      = (!o_valid || i_ready) && !fifo_empty;
        pop       = load && last_lane;
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = STREAM;
            STREAM:  if (o_valid && o_last && i_ready && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data     <= '0;
            o_lane     <= '0;
            o_last     <= 1'b0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            lane_cnt   <= '0;
        end else begin
            if (load) begin
                o_data   <= sat_round_shift(lane_value, i_shift);
                o_lane   <= lane_cnt;
                o_last   <= last_lane;
                o_valid  <= 1'b1;
                lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            // A drop wins over a simultaneous clear so no lost set goes unreported.
            if (drop)
                o_overflow <= 1'b1;
            else if (i_clr_ovf)
                o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvm_out_serializer.sv
// Directed bench for mvm_out_serializer: latency, stalls, overflow, full-FIFO
// pop/push, back-to-back streaming, requant corners and async reset.
module tb_mvm_out_serializer;
    import mvm_pkg::*;

    localparam int SET_DEPTH = 4;
    localparam int CNTW      = $clog2(SET_DEPTH) + 1;
    localparam int OW        = 2 + LANEW + OWIDTH;

    typedef logic [NUM_OLANES*DATAW-1:0] set_t;

    localparam int A_IN [8] = '{24, -24, 5000, -5000, 0, 8, -8, 127};
    localparam int A_EX [8] = '{2, -1, 127, -128, 0, 1, 0, 8};
    localparam int R_SH [2] = '{1, 0};
    localparam int R_IN [2][8] = '{'{200, -200, 127, -128, 3, -3, 1, -1},
                                   '{128, -129, 127, -128, 1000000, -1000000, 0, -1}};
    localparam int R_EX [2][8] = '{'{100, -100, 64, -64, 2, -1, 1, 0},
                                   '{127, -128, 127, -128, 127, -128, 0, -1}};

    logic              clk = 1'b0;
    logic              rst;
    set_t              i_result;
    logic              i_valid;
    logic [SHIFTW-1:0] i_shift;
    logic              i_clr_ovf;
    logic              i_ready;
    logic [OWIDTH-1:0] o_data;
    logic [LANEW-1:0]  o_lane;
    logic              o_last;
    logic              o_valid;
    logic [CNTW-1:0]   o_count;
    logic              o_overflow;
    logic              o_busy;

    int errors = 0;
    int checks = 0;

    mvm_out_serializer #(.SET_DEPTH(SET_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_result   (i_result),
        .i_valid    (i_valid),
        .i_shift    (i_shift),
        .i_clr_ovf  (i_clr_ovf),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_lane     (o_lane),
        .o_last     (o_last),
        .o_valid    (o_valid),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic set_t mk_tag(int tag);
        set_t s;
        for (int l = 0; l < NUM_OLANES; l++)
            s[l*DATAW +: DATAW] = DATAW'(tag*10 + l);
        return s;
    endfunction

    function automatic set_t mk_set_a();
        set_t s;
        for (int l = 0; l < NUM_OLANES; l++)
            s[l*DATAW +: DATAW] = DATAW'(A_IN[l]);
        return s;
    endfunction

    function automatic logic [OW-1:0] exp_word(int l, int v);
        return {1'b1, LANEW'(l), (l == NUM_OLANES-1), OWIDTH'(v)};
    endfunction

    task automatic test_reset();
        rst = 1'b0; i_valid = 1'b0; i_result = '0; i_shift = '0;
        i_clr_ovf = 1'b0; i_ready = 1'b1;
        #12;
        if ({o_data, o_lane, o_last, o_valid} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", {o_data, o_lane, o_last, o_valid});
        end
        checks++;
        if ({o_count, o_overflow, o_busy} !== '0) begin
            errors++; $display("FAIL reset_status got=%h want=0", {o_count, o_overflow, o_busy});
        end
        checks++;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        i_shift = SHIFTW'(4); i_ready = 1'b1;
        i_result = mk_set_a(); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        if ({o_valid, o_count} !== {1'b0, CNTW'(1)}) begin
            errors++; $display("FAIL single_latency got=%h want=%h", {o_valid, o_count}, {1'b0, CNTW'(1)});
        end
        checks++;
        tick();
        for (int l = 0; l < NUM_OLANES; l++) begin
            if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, A_EX[l])) begin
                errors++; $display("FAIL single lane=%0d got=%h want=%h", l, {o_valid, o_lane, o_last, o_data}, exp_word(l, A_EX[l]));
            end
            checks++;
            if (l == NUM_OLANES-1) begin
                if ({o_busy, o_count} !== {1'b1, CNTW'(0)}) begin
                    errors++; $display("FAIL single_last_busy got=%h want=%h", {o_busy, o_count}, {1'b1, CNTW'(0)});
                end
                checks++;
            end
            tick();
        end
        if ({o_valid, o_busy} !== 2'b00) begin
            errors++; $display("FAIL single_idle got=%b want=00", {o_valid, o_busy});
        end
        checks++;
    endtask

    task automatic test_stall();
        i_shift = '0; i_ready = 1'b1;
        i_result = mk_tag(1); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        for (int l = 0; l < NUM_OLANES; l++) begin
            if (l == 3) begin
                i_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    if ({o_valid, o_lane, o_last, o_data} !== exp_word(3, 13)) begin
                        errors++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", c, {o_valid, o_lane, o_last, o_data}, exp_word(3, 13));
                    end
                    checks++;
                end
                i_ready = 1'b1;
            end
            if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, 10 + l)) begin
                errors++; $display("FAIL stall lane=%0d got=%h want=%h", l, {o_valid, o_lane, o_last, o_data}, exp_word(l, 10 + l));
            end
            checks++;
            tick();
        end
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL stall_idle got=%b want=0", o_valid);
        end
        checks++;
    endtask

    task automatic test_requant();
        for (int p = 0; p < 2; p++) begin
            set_t s;
            for (int l = 0; l < NUM_OLANES; l++)
                s[l*DATAW +: DATAW] = DATAW'(R_IN[p][l]);
            i_shift = SHIFTW'(R_SH[p]); i_ready = 1'b1;
            i_result = s; i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            tick();
            for (int l = 0; l < NUM_OLANES; l++) begin
                if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, R_EX[p][l])) begin
                    errors++; $display("FAIL requant shift=%0d lane=%0d got=%h want=%h", R_SH[p], l, {o_valid, o_lane, o_last, o_data}, exp_word(l, R_EX[p][l]));
                end
                checks++;
                tick();
            end
        end
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL requant_idle got=%b want=0", o_busy);
        end
        checks++;
    endtask

    task automatic test_overflow();
        i_shift = '0; i_ready = 1'b0;
        for (int t = 2; t <= 6; t++) begin
            i_result = mk_tag(t); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        if ({o_count, o_overflow} !== {CNTW'(4), 1'b1}) begin
            errors++; $display("FAIL ovf_set got=%h want=%h", {o_count, o_overflow}, {CNTW'(4), 1'b1});
        end
        checks++;
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        if (o_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got=%b want=0", o_overflow);
        end
        checks++;
        i_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int l = 0; l < NUM_OLANES; l++) begin
                if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, (2 + s)*10 + l)) begin
                    errors++; $display("FAIL ovf_drain set=%0d lane=%0d got=%h want=%h", s, l, {o_valid, o_lane, o_last, o_data}, exp_word(l, (2 + s)*10 + l));
                end
                checks++;
                tick();
            end
        end
        if ({o_valid, o_count} !== {1'b0, CNTW'(0)}) begin
            errors++; $display("FAIL ovf_dropped_absent got=%h want=%h", {o_valid, o_count}, {1'b0, CNTW'(0)});
        end
        checks++;
    endtask

    task automatic test_full_pop();
        i_shift = '0; i_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            i_result = mk_tag(t); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        if ({o_count, o_overflow} !== {CNTW'(4), 1'b0}) begin
            errors++; $display("FAIL full_fill got=%h want=%h", {o_count, o_overflow}, {CNTW'(4), 1'b0});
        end
        checks++;
        i_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int l = 0; l < NUM_OLANES; l++) begin
                if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, (1 + s)*10 + l)) begin
                    errors++; $display("FAIL full_drain set=%0d lane=%0d got=%h want=%h", s, l, {o_valid, o_lane, o_last, o_data}, exp_word(l, (1 + s)*10 + l));
                end
                checks++;
                // Lane 6 accepted here loads lane 7 and pops the head while full.
                if (s == 0 && l == 6) begin
                    i_result = mk_tag(5); i_valid = 1'b1;
                end
                tick();
                if (s == 0 && l == 6) begin
                    i_valid = 1'b0;
                    if ({o_count, o_overflow} !== {CNTW'(4), 1'b0}) begin
                        errors++; $display("FAIL full_pop_push got=%h want=%h", {o_count, o_overflow}, {CNTW'(4), 1'b0});
                    end
                    checks++;
                end
            end
        end
        if ({o_valid, o_busy} !== 2'b00) begin
            errors++; $display("FAIL full_idle got=%b want=00", {o_valid, o_busy});
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        i_shift = '0; i_ready = 1'b1;
        i_result = mk_tag(7); i_valid = 1'b1;
        tick();
        i_result = mk_tag(8);
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 2*NUM_OLANES; i++) begin
            if ({o_valid, o_lane, o_last, o_data} !== exp_word(i % NUM_OLANES, (7 + i/NUM_OLANES)*10 + i % NUM_OLANES)) begin
                errors++; $display("FAIL b2b cyc=%0d got=%h want=%h", i + 1, {o_valid, o_lane, o_last, o_data}, exp_word(i % NUM_OLANES, (7 + i/NUM_OLANES)*10 + i % NUM_OLANES));
            end
            checks++;
            tick();
        end
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end got=%b want=0", o_valid);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        i_shift = '0; i_ready = 1'b1;
        i_result = mk_tag(9); i_valid = 1'b1;
        tick();
        i_result = mk_tag(1);
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        if ({o_valid, o_lane} !== {1'b1, LANEW'(3)}) begin
            errors++; $display("FAIL arst_pre got=%h want=%h", {o_valid, o_lane}, {1'b1, LANEW'(3)});
        end
        checks++;
        #2;
        rst = 1'b0;
        #1;
        if ({o_data, o_lane, o_last, o_valid} !== '0) begin
            errors++; $display("FAIL arst_outputs got=%h want=0", {o_data, o_lane, o_last, o_valid});
        end
        checks++;
        if ({o_count, o_overflow, o_busy} !== '0) begin
            errors++; $display("FAIL arst_status got=%h want=0", {o_count, o_overflow, o_busy});
        end
        checks++;
        @(posedge clk); #1;
        rst = 1'b1;
        i_shift = SHIFTW'(4);
        tick();
        i_result = mk_set_a(); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        for (int l = 0; l < NUM_OLANES; l++) begin
            if ({o_valid, o_lane, o_last, o_data} !== exp_word(l, A_EX[l])) begin
                errors++; $display("FAIL arst_after lane=%0d got=%h want=%h", l, {o_valid, o_lane, o_last, o_data}, exp_word(l, A_EX[l]));
            end
            checks++;
            tick();
        end
        if ({o_valid, o_busy} !== 2'b00) begin
            errors++; $display("FAIL arst_discard got=%b want=00", {o_valid, o_busy});
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_requant();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
